// File: rtl/instr_mem_loader_if.sv
// Write-direction req/gnt/rvalid memory bus between the program loader and the instruction sp_ram.
// Signal names keep the loader's port naming so traces line up with the core's memory port.
interface instr_mem_loader_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  mem_req_o;
   logic                  mem_gnt_i;
   logic                  mem_rvalid_i;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic                  mem_we_o;
   logic [3:0]            mem_be_o;
   logic [31:0]           mem_wdata_o;

   modport master (
      output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i
   );

   modport slave (
      input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to consecutive
// instruction-memory words; releases core fetch once the whole image is in place.
module instr_mem_loader #(
   parameter int          ADDR_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h00000000,
   parameter int          NUM_WORDS  = 256
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [15:0]         len_i,
   input  logic                byte_valid_i,
   input  logic [7:0]          byte_data_i,
   output logic                byte_ready_o,
   instr_mem_loader_if.master  mem,
   output logic                busy_o,
   output logic                done_o,
   output logic                fetch_enable_o,
   output logic [15:0]         words_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_REQ     = 3'd2;
   localparam logic [2:0] S_WAIT_RV = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [15:0] MAX_WORDS = 16'(NUM_WORDS);

   logic [2:0]            state;
   logic [15:0]           len_q;
   logic [15:0]           words_q;
   logic [1:0]            byte_idx;
   logic [23:0]           asm_q;
   logic [31:0]           wdata_q;
   logic [15:0]           len_eff;
   logic [ADDR_WIDTH-1:0] addr_w;

   assign len_eff = (len_i > MAX_WORDS) ? MAX_WORDS : len_i;
   assign addr_w  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({words_q, 2'b00});

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         len_q    <= '0;
         words_q  <= '0;
         byte_idx <= '0;
         asm_q    <= '0;
         wdata_q  <= '0;
      end else begin
         case (state)
            S_COLLECT: begin
               if (byte_valid_i) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: asm_q[7:0]   <= byte_data_i;
                     2'd1: asm_q[15:8]  <= byte_data_i;
                     2'd2: asm_q[23:16] <= byte_data_i;
                     default: begin
                        // wdata only moves on word completion so it holds outside REQ/WAIT_RV
                        wdata_q <= {byte_data_i, asm_q};
                        state   <= S_REQ;
                     end
                  endcase
               end
            end
            S_REQ: begin
               if (mem.mem_gnt_i) state <= S_WAIT_RV;
            end
            S_WAIT_RV: begin
               if (mem.mem_rvalid_i) begin
                  words_q <= words_q + 16'd1;
                  state   <= (words_q + 16'd1 == len_q) ? S_DONE : S_COLLECT;
               end
            end
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  len_q    <= len_eff;
                  words_q  <= '0;
                  byte_idx <= '0;
                  state    <= (len_eff == 16'd0) ? S_DONE : S_COLLECT;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign byte_ready_o    = (state == S_COLLECT);
   assign busy_o          = (state == S_COLLECT) || (state == S_REQ) || (state == S_WAIT_RV);
   assign done_o          = (state == S_DONE);
   assign fetch_enable_o  = (state == S_DONE);
   assign words_o         = words_q;

   assign mem.mem_req_o   = (state == S_REQ);
   assign mem.mem_we_o    = (state == S_REQ);
   assign mem.mem_be_o    = (state == S_REQ) ? 4'b1111 : 4'b0000;
   assign mem.mem_addr_o  = (state == S_REQ) ? addr_w : '0;
   assign mem.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed-plus-random bench for instr_mem_loader: sp_ram slave model with grant stalls and
// variable rvalid latency; expected writes derived from the byte stream and the clamped length.
module tb_instr_mem_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i, start_i, byte_valid_i;
   logic [15:0] len_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o, busy_o, done_o, fetch_enable_o;
   logic [15:0] words_o;

   instr_mem_loader_if #(.ADDR_WIDTH(32)) mif ();

   instr_mem_loader #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0), .NUM_WORDS(256)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
      .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
      .mem(mif), .busy_o(busy_o), .done_o(done_o), .fetch_enable_o(fetch_enable_o),
      .words_o(words_o)
   );

   int checks = 0, errors = 0;
   logic [7:0]  stream[$];
   logic [31:0] wr_addr_q[$], wr_data_q[$];
   int          req_cyc_q[$];
   int stall_max = 0, forced_stall = -1, rv_lat_max = 1;
   int rv_cnt = 0, stall_left = 0, req_cycles = 0, bytes_acc = 0;
   bit in_req = 0;
   logic [31:0] a0, d0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // sp_ram slave: drives gnt/rvalid on the falling edge, records each granted write
   always @(negedge clk) begin
      mif.mem_rvalid_i = 1'b0;
      mif.mem_gnt_i    = 1'b0;
      if (rst_i) begin
         rv_cnt = 0;
         in_req = 0;
      end else begin
         if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) mif.mem_rvalid_i = 1'b1;
         end
         if (mif.mem_req_o) begin
            if (!in_req) begin
               in_req     = 1;
               stall_left = (forced_stall >= 0) ? forced_stall : int'($urandom_range(0, stall_max));
               a0         = mif.mem_addr_o;
               d0         = mif.mem_wdata_o;
               req_cycles = 0;
            end else begin
               chk("req_addr_stable", mif.mem_addr_o, a0);
               chk("req_wdata_stable", mif.mem_wdata_o, d0);
            end
            req_cycles++;
            if (stall_left > 0) stall_left--;
            else begin
               mif.mem_gnt_i = 1'b1;
               in_req = 0;
               wr_addr_q.push_back(mif.mem_addr_o);
               wr_data_q.push_back(mif.mem_wdata_o);
               req_cyc_q.push_back(req_cycles);
               rv_cnt = int'($urandom_range(1, rv_lat_max));
            end
         end else begin
            in_req = 0;
         end
      end
   end

   task automatic make_stream(input int n);
      stream.delete();
      for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
   endtask

   task automatic start_load(input int len);
      wr_addr_q.delete(); wr_data_q.delete(); req_cyc_q.delete();
      @(negedge clk);
      start_i = 1'b1;
      len_i   = len[15:0];
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic stream_run(input int pct_valid, input bit poke, input bit stop_mid);
      int idx = 0, cyc = 0;
      bit poked1 = 0, poked2 = 0, timed_out = 0;
      bytes_acc = 0;
      forever begin
         if (!stop_mid && done_o) break;
         if (stop_mid && words_o == 16'd1 && mif.mem_req_o) break;
         if (cyc >= 20000) begin timed_out = 1; break; end
         start_i = 1'b0;
         if (poke && !poked1 && byte_ready_o && bytes_acc == 2) begin
            start_i = 1'b1; len_i = 16'd7; poked1 = 1;
         end else if (poke && !poked2 && busy_o && !byte_ready_o && words_o == 16'd1) begin
            start_i = 1'b1; len_i = 16'd0; poked2 = 1;
         end
         byte_valid_i = (idx < stream.size()) && ($urandom_range(0, 99) < pct_valid);
         byte_data_i  = (idx < stream.size()) ? stream[idx] : 8'h00;
         if (byte_valid_i && byte_ready_o) begin idx++; bytes_acc++; end
         @(negedge clk);
         cyc++;
      end
      byte_valid_i = 1'b0;
      start_i      = 1'b0;
      chk("no_timeout", 32'(timed_out), 32'd0);
   endtask

   // Reference: word i of the image is stream bytes 4i..4i+3, little-endian, at byte address 4i
   task automatic verify_load(input int req_len);
      int l;
      l = (req_len > 256) ? 256 : req_len;
      chk("num_writes", wr_addr_q.size(), l);
      for (int i = 0; i < l && i < wr_addr_q.size(); i++) begin
         chk($sformatf("wr_addr[%0d]", i), wr_addr_q[i], 32'(4 * i));
         chk($sformatf("wr_data[%0d]", i), wr_data_q[i],
             {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]});
      end
      chk("words_final", 32'(words_o), l);
      chk("done_final", 32'(done_o), 32'd1);
      chk("fetch_final", 32'(fetch_enable_o), 32'd1);
      chk("busy_final", 32'(busy_o), 32'd0);
   endtask

   task automatic check_zero_outputs(input string pfx);
      chk({pfx, "_byte_ready"}, 32'(byte_ready_o), 32'd0);
      chk({pfx, "_req"}, 32'(mif.mem_req_o), 32'd0);
      chk({pfx, "_we"}, 32'(mif.mem_we_o), 32'd0);
      chk({pfx, "_be"}, 32'(mif.mem_be_o), 32'd0);
      chk({pfx, "_addr"}, mif.mem_addr_o, 32'd0);
      chk({pfx, "_wdata"}, mif.mem_wdata_o, 32'd0);
      chk({pfx, "_busy"}, 32'(busy_o), 32'd0);
      chk({pfx, "_done"}, 32'(done_o), 32'd0);
      chk({pfx, "_fetch"}, 32'(fetch_enable_o), 32'd0);
      chk({pfx, "_words"}, 32'(words_o), 32'd0);
   endtask

   int hi_cnt;

   initial begin
      rst_i = 1'b1; start_i = 1'b0; len_i = '0; byte_valid_i = 1'b0; byte_data_i = '0;
      mif.mem_gnt_i = 1'b0; mif.mem_rvalid_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      check_zero_outputs("reset");

      // zero-length load straight from IDLE
      start_load(0);
      chk("len0_done", 32'(done_o), 32'd1);
      chk("len0_fetch", 32'(fetch_enable_o), 32'd1);
      hi_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (byte_ready_o || mif.mem_req_o) hi_cnt++;
         @(negedge clk);
      end
      chk("len0_no_ready_or_req", hi_cnt, 0);
      chk("len0_writes", wr_addr_q.size(), 0);
      chk("len0_words", 32'(words_o), 32'd0);

      // two-word program, same-cycle grant, next-cycle rvalid
      stream = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
      stall_max = 0; forced_stall = -1; rv_lat_max = 1;
      start_load(2);
      chk("restart_fetch_drop", 32'(fetch_enable_o), 32'd0);
      chk("restart_busy", 32'(busy_o), 32'd1);
      stream_run(100, 0, 0);
      verify_load(2);
      if (wr_data_q.size() == 2) begin
         chk("prog_word0", wr_data_q[0], 32'h00000013);
         chk("prog_word1", wr_data_q[1], 32'h0000006F);
      end

      // grant held low 3 cycles: request visible for 4 cycles, one write
      make_stream(4);
      forced_stall = 3;
      start_load(1);
      stream_run(100, 0, 0);
      verify_load(1);
      if (req_cyc_q.size() > 0) chk("stall_req_cycles", req_cyc_q[0], 4);
      forced_stall = -1;

      // over-length request clamps to capacity
      make_stream(1200);
      stall_max = 2; rv_lat_max = 2;
      start_load(300);
      stream_run(100, 0, 0);
      verify_load(300);
      chk("clamp_bytes_accepted", bytes_acc, 1024);
      if (wr_addr_q.size() > 0) chk("clamp_last_addr", wr_addr_q[wr_addr_q.size()-1], 32'h3FC);
      hi_cnt = 0;
      byte_valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (byte_ready_o) hi_cnt++;
         @(negedge clk);
      end
      byte_valid_i = 1'b0;
      chk("clamp_ready_low_after", hi_cnt, 0);

      // gappy stream with ignored mid-load starts
      make_stream(24);
      start_load(6);
      stream_run(60, 1, 0);
      verify_load(6);

      // reset while word 1 sits in REQ, then a fresh one-word load
      make_stream(12);
      forced_stall = 20;
      start_load(3);
      stream_run(100, 0, 1);
      chk("mid_in_req", 32'(mif.mem_req_o), 32'd1);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      check_zero_outputs("midrst");
      forced_stall = -1; stall_max = 0; rv_lat_max = 1;
      make_stream(4);
      start_load(1);
      stream_run(100, 0, 0);
      verify_load(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Bus initiator that writes a program image into the instruction sp_ram before the core runs.
- It drives the req/gnt/rvalid memory protocol in the write direction. The core only ever reads that memory.
- Input is a byte stream over a valid/ready handshake, for example from a UART or testbench. Bytes are packed little-endian into 32-bit words and written at consecutive word addresses.
- `fetch_enable_o` is held low until the load completes, then gates the core's `fetch_enable_i`.

Parameters:
- ADDR_WIDTH, 32, width of `mem_addr_o`.
- BASE_ADDR, 32'h00000000, byte address of the first word written.
- NUM_WORDS, 256, capacity of the target memory in words; requested lengths are clamped to this.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  begin a load; sampled only in IDLE or DONE
- len_i  in  16  number of words to load; sampled with `start_i`
- byte_valid_i  in  1  stream byte valid
- byte_data_i  in  8  stream byte
- byte_ready_o  out  1  loader accepts a byte this cycle
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid (write acknowledge)
- mem_addr_o  out  ADDR_WIDTH  byte address
- mem_we_o  out  1  write enable
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  write data
- busy_o  out  1  load in progress
- done_o  out  1  last load completed
- fetch_enable_o  out  1  core fetch enable
- words_o  out  16  words written in the current or last load

Behaviour:
- Reset (`rst_i` high at a clock edge) forces state IDLE. All outputs read 0: `byte_ready_o`, `mem_req_o`, `mem_we_o`, `busy_o`, `done_o`, `fetch_enable_o`, `words_o`, `mem_addr_o`, `mem_wdata_o`. `mem_be_o` = 4'b0000.
- Reset mid-load aborts immediately, even with `mem_req_o` high. The partial image is abandoned.
- States: IDLE, COLLECT, REQ, WAIT_RV, DONE.
- IDLE, with `start_i` = 1:
  - The effective length is latched as L = min(`len_i`, NUM_WORDS). `words_o` is cleared, the byte index is cleared, and `done_o` is cleared.
  - If L = 0, go to DONE. Otherwise go to COLLECT.
- COLLECT:
  - `byte_ready_o` = 1, and it is 1 only in this state.
  - A byte transfers when `byte_valid_i` and `byte_ready_o` are both high. Byte k (k = 0..3) lands in `wdata[8k+7:8k]`.
  - On the transfer of byte 3, the next state is REQ. The byte index wraps to 0.
  - No byte is accepted in any other state.
- REQ:
  - Outputs: `mem_req_o` = 1, `mem_we_o` = 1, `mem_be_o` = 4'b1111, `mem_addr_o` = BASE_ADDR + 4·`words_o` (truncated to ADDR_WIDTH).
  - Address and data are held stable while `mem_gnt_i` = 0.
  - On the cycle `mem_gnt_i` = 1 is sampled: drop `mem_req_o` next cycle and go to WAIT_RV.
- WAIT_RV:
  - `mem_req_o` = 0. Wait for `mem_rvalid_i` = 1; there is no timeout.
  - `mem_rvalid_i` is required at least 1 cycle after the grant. An rvalid while not in WAIT_RV is ignored.
  - On rvalid, `words_o` increments. If the new `words_o` = L, go to DONE. Otherwise go to COLLECT.
- DONE:
  - `done_o` = 1 and `fetch_enable_o` = 1, held level until the next `start_i`.
  - A `start_i` in DONE behaves as in IDLE, and `fetch_enable_o` drops the next cycle.
- `busy_o` = 1 in COLLECT, REQ and WAIT_RV.
- `start_i` in COLLECT, REQ or WAIT_RV is ignored.
- Throughput per word: 4 byte cycles minimum, plus 1 REQ cycle (more if the grant stalls), plus at least 1 WAIT_RV cycle.
- `mem_wdata_o` shows the assembled word in REQ and WAIT_RV. In other states it holds its last value (0 after reset).

Test Plan:
- Start with `len_i` = 2 and stream bytes 0x13,0x00,0x00,0x00,0x6F,0x00,0x00,0x00, using an sp_ram model with same-cycle gnt and next-cycle rvalid.
  -> Writes land at addr 0x0 (data 0x00000013) and addr 0x4 (data 0x0000006F). `words_o` = 2, `done_o` = 1, `fetch_enable_o` = 1.
- Hold `mem_gnt_i` low for 3 cycles in REQ.
  -> `mem_req_o`, `mem_addr_o` and `mem_wdata_o` stay constant for all 4 cycles. Exactly one write is recorded.
- Start with `len_i` = 0.
  -> DONE the cycle after start. No `mem_req_o` pulse. `byte_ready_o` never asserts. `words_o` = 0.
- Start with `len_i` = 300 and NUM_WORDS = 256, streaming 1200 bytes.
  -> Exactly 256 writes, last address 0x3FC. `byte_ready_o` stays low after byte 1024.
- Deassert `byte_valid_i` randomly, and pulse `start_i` in COLLECT and again in WAIT_RV.
  -> Word packing is unaffected. The extra starts are ignored, and `words_o` reaches the original L.
- Assert `rst_i` for 1 cycle while in REQ on word 1, then restart with `len_i` = 1.
  -> All outputs are 0 the cycle after reset. The new load writes addr 0x0, not 0x4.
